// File: rtl/xmr_probe_capture_pkg.sv
// xmr_probe_pkg: shared types and constants for the probe capture block
package xmr_probe_pkg;
  localparam int PROBE_W_DEF = 1;
  localparam int TS_W_DEF = 16;
  localparam logic [7:0] OVF_MAX = 8'hFF;
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [PROBE_W_DEF-1:0] value;
  } probe_entry_t;
  typedef enum logic [1:0] {CAP_OFF = 2'd0, CAP_ARM = 2'd1, CAP_RUN = 2'd2} cap_state_e;
endpackage

// File: rtl/xmr_probe_capture_if.sv
// xmr_probe_capture_if: valid/ready stream carrying logged {ts, value} entries
interface xmr_probe_capture_if #(parameter int W = 17);
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  modport master(output out_valid, output out_data, input out_ready);
  modport slave(input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/xmr_probe_capture_fifo.sv
// xmr_probe_fifo: show-ahead synchronous FIFO, wrap bit on pointers separates full from empty
module xmr_probe_fifo
  import xmr_probe_pkg::*;
#(
  parameter int W = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_pop, w_push;
  assign empty = r_wptr == r_rptr;
  assign full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop = pop & !empty;
  assign w_push = push & (!full | w_pop);
  assign rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];
  // pointer advance; a pop frees the slot a same-cycle push into a full FIFO needs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
  // storage, no reset needed since empty masks the head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/xmr_probe_capture.sv
// xmr_probe_capture: timestamps every probe change and queues it for a stream consumer
module xmr_probe_capture
  import xmr_probe_pkg::*;
#(
  parameter int PROBE_W = 1,
  parameter int TS_W = 16,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PROBE_W-1:0] probe_i,
  xmr_probe_capture_if.master out,
  output logic               full,
  output logic [7:0]         overflow_cnt
);
  localparam logic [1:0] S_OFF = 2'(CAP_OFF);
  localparam logic [1:0] S_ARM = 2'(CAP_ARM);
  localparam logic [1:0] S_RUN = 2'(CAP_RUN);
  logic [1:0] r_state;
  logic [TS_W-1:0] r_ts;
  logic [PROBE_W-1:0] r_prev;
  logic [7:0] r_ovf;
  logic w_run, w_event, w_pop, w_push, w_empty, w_full;
  logic [TS_W+PROBE_W-1:0] w_rdata;
  assign w_run = (r_state == S_RUN) & en;
  assign w_event = w_run & (probe_i != r_prev);
  assign w_pop = out.out_valid & out.out_ready;
  assign w_push = w_event & (!w_full | w_pop);
  assign out.out_valid = !w_empty;
  assign out.out_data = w_rdata;
  assign full = w_full;
  assign overflow_cnt = r_ovf;
  // capture FSM, free-running timestamp outside OFF, change reference and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
      r_ts <= '0;
      r_prev <= '0;
      r_ovf <= '0;
    end else begin
      r_state <= en ? (r_state == S_OFF ? S_ARM : S_RUN) : S_OFF;
      if (r_state != S_OFF) r_ts <= r_ts + 1'b1;
      if (r_state == S_ARM || w_run) r_prev <= probe_i;
      if (w_event && w_full && !w_pop && r_ovf != OVF_MAX) r_ovf <= r_ovf + 1'b1;
    end
  end
  xmr_probe_fifo #(.W(TS_W + PROBE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .wdata({r_ts, probe_i}),
    .rdata(w_rdata),
    .empty(w_empty),
    .full(w_full)
  );
endmodule

// File: tb/tb_xmr_probe_capture.sv
// tb_xmr_probe_capture: directed checks of change logging, FIFO limits, ts wrap, enable and reset
module tb_xmr_probe_capture;
  import xmr_probe_pkg::*;
  logic clk = 0, rst, en, probe, en2, probe2, full, full2;
  logic [7:0] ovf, ovf2;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  xmr_probe_capture_if #(.W(17)) s_if ();
  xmr_probe_capture_if #(.W(5)) s2_if ();
  xmr_probe_capture #(.PROBE_W(1), .TS_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .probe_i(probe), .out(s_if), .full(full), .overflow_cnt(ovf)
  );
  xmr_probe_capture #(.PROBE_W(1), .TS_W(4), .DEPTH(8)) dut_w (
    .clk(clk), .rst(rst), .en(en2), .probe_i(probe2), .out(s2_if), .full(full2), .overflow_cnt(ovf2)
  );
  typedef struct {
    logic en;
    logic probe;
    logic rdy;
    logic exp_valid;
    logic [16:0] exp_data;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; en = 0; probe = 0; en2 = 0; probe2 = 0;
    s_if.out_ready = 0; s2_if.out_ready = 0;
    tick(); tick();
    rst = 0;
  endtask
  function automatic logic [16:0] ent(input int t, input logic b);
    probe_entry_t e;
    e.ts = 16'(t);
    e.value = b;
    return e;
  endfunction
  initial begin
    v[0] = '{1, 0, 1, 0, 17'd0};
    v[1] = '{1, 0, 1, 0, 17'd0};
    v[2] = '{1, 0, 1, 0, 17'd0};
    v[3] = '{1, 0, 1, 0, 17'd0};
    v[4] = '{1, 1, 1, 1, ent(3, 1)};
    v[5] = '{1, 1, 1, 0, 17'd0};
    v[6] = '{1, 0, 1, 1, ent(5, 0)};
    v[7] = '{1, 0, 1, 0, 17'd0};
    v[8] = '{1, 1, 1, 1, ent(7, 1)};
    v[9] = '{1, 1, 1, 0, 17'd0};
    v[10] = '{1, 0, 1, 1, ent(9, 0)};
    v[11] = '{1, 0, 1, 0, 17'd0};
    do_reset();
    chk("rst valid", 32'(s_if.out_valid), 0);
    chk("rst data", 32'(s_if.out_data), 0);
    chk("rst full", 32'(full), 0);
    chk("rst ovf", 32'(ovf), 0);
    // toggles every 2 cycles with a ready consumer
    for (int i = 0; i < 12; i++) begin
      en = v[i].en; probe = v[i].probe; s_if.out_ready = v[i].rdy;
      tick();
      chk($sformatf("t1 valid %0d", i), 32'(s_if.out_valid), 32'(v[i].exp_valid));
      chk($sformatf("t1 data %0d", i), 32'(s_if.out_data), 32'(v[i].exp_data));
    end
    chk("t1 ovf", 32'(ovf), 0);
    // fill past capacity with no consumer
    do_reset();
    en = 1; tick(); tick();
    for (int k = 1; k <= 10; k++) begin
      probe = k[0];
      tick();
      if (k == 7) chk("t2 full7", 32'(full), 0);
      if (k == 8) chk("t2 full8", 32'(full), 1);
    end
    chk("t2 ovf", 32'(ovf), 2);
    en = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2 valid %0d", i), 32'(s_if.out_valid), 1);
      chk($sformatf("t2 data %0d", i), 32'(s_if.out_data), 32'(ent(i + 1, (i % 2) == 0)));
      s_if.out_ready = 1;
      tick();
    end
    chk("t2 empty", 32'(s_if.out_valid), 0);
    chk("t2 ovf keep", 32'(ovf), 2);
    // push and pop together while full
    do_reset();
    en = 1; tick(); tick();
    for (int k = 1; k <= 8; k++) begin
      probe = k[0];
      tick();
    end
    chk("t3 full pre", 32'(full), 1);
    probe = 1; s_if.out_ready = 1;
    tick();
    chk("t3 full post", 32'(full), 1);
    chk("t3 ovf", 32'(ovf), 0);
    en = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3 data %0d", i), 32'(s_if.out_data), 32'(ent(i + 2, ((i + 2) % 2) == 1)));
      tick();
    end
    chk("t3 empty", 32'(s_if.out_valid), 0);
    // timestamp wrap on the narrow instance
    do_reset();
    en2 = 1;
    for (int c = 0; c < 16; c++) tick();
    probe2 = 1; tick();
    probe2 = 0; tick();
    chk("t4 valid a", 32'(s2_if.out_valid), 1);
    chk("t4 data a", 32'(s2_if.out_data), 32'h1F);
    s2_if.out_ready = 1; tick();
    chk("t4 valid b", 32'(s2_if.out_valid), 1);
    chk("t4 data b", 32'(s2_if.out_data), 0);
    tick();
    chk("t4 empty", 32'(s2_if.out_valid), 0);
    en2 = 0;
    // probe activity while disabled is never logged
    do_reset();
    en = 1; s_if.out_ready = 1;
    for (int c = 0; c < 4; c++) tick();
    en = 0;
    for (int c = 0; c < 5; c++) begin
      probe = ~probe;
      tick();
      chk($sformatf("t5 off %0d", c), 32'(s_if.out_valid), 0);
    end
    en = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t5 rearm %0d", c), 32'(s_if.out_valid), 0);
    end
    probe = 0; tick();
    chk("t5 valid", 32'(s_if.out_valid), 1);
    chk("t5 value", 32'(s_if.out_data[0]), 0);
    // reset with entries queued, then saturate the drop counter
    do_reset();
    en = 1; tick(); tick();
    for (int k = 1; k <= 11; k++) begin
      probe = k[0];
      tick();
    end
    en = 0; s_if.out_ready = 1;
    for (int c = 0; c < 5; c++) tick();
    s_if.out_ready = 0;
    chk("t6 queued", 32'(s_if.out_valid), 1);
    chk("t6 ovf pre", 32'(ovf), 3);
    rst = 1; probe = 0; tick(); rst = 0;
    chk("t6 valid", 32'(s_if.out_valid), 0);
    chk("t6 ovf", 32'(ovf), 0);
    chk("t6 full", 32'(full), 0);
    en = 1; tick(); tick();
    probe = 1; tick();
    chk("t6 ts0", 32'(s_if.out_data), 32'(ent(1, 1)));
    for (int k = 0; k < 261; k++) begin
      probe = ~probe;
      tick();
    end
    chk("t6 ovf254", 32'(ovf), 254);
    for (int k = 0; k < 50; k++) begin
      probe = ~probe;
      tick();
    end
    chk("t6 ovf sat", 32'(ovf), 255);
    chk("t6 head", 32'(s_if.out_data), 32'(ent(1, 1)));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
